// File: rtl/arch_rf_pkg.sv
// Shared types and sizing for the architectural register file.
// Optional feature: define ARCH_RF_X0_ZERO_EN to hard-wire register 0 to zero.
`ifndef ARCH_REG_NUM
`define ARCH_REG_NUM 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef MAX_NUM_OF_COMMITS
`define MAX_NUM_OF_COMMITS 2
`endif

package arch_rf_pkg;
  localparam int RF_NUM_REGS    = `ARCH_REG_NUM;
  localparam int RF_DATA_W      = `REG_VAL_WIDTH;
  localparam int RF_NUM_COMMITS = `MAX_NUM_OF_COMMITS;
  localparam int RF_CLR_PER_CYC = 4;
  localparam int RF_AW          = $clog2(RF_NUM_REGS);

`ifdef ARCH_RF_X0_ZERO_EN
  localparam bit RF_X0_ZERO = 1'b1;
`else
  localparam bit RF_X0_ZERO = 1'b0;
`endif

  // A single-step sweep still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int SWEEP_CNT_W = cnt_width(RF_NUM_REGS / RF_CLR_PER_CYC);

  typedef logic [RF_AW-1:0]     arch_reg_idx_t;
  typedef logic [RF_DATA_W-1:0] reg_val_t;
  typedef enum logic {RF_IDLE, RF_CLEAR} arch_rf_state_e;
endpackage

// File: rtl/arch_rf_fwd_mux.sv
// Per-read-port priority forward mux: the highest-index matching commit overrides the array value.
// Honours ARCH_RF_X0_ZERO_EN through the package flag (register 0 always reads zero).
module arch_rf_fwd_mux
  import arch_rf_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int NUM_COMMITS = RF_NUM_COMMITS,
  parameter int AW          = RF_AW
) (
  input  logic [AW-1:0]                        rd_addr,
  input  logic [DATA_W-1:0]                    arr_val,
  input  logic [NUM_COMMITS-1:0]               cm_wr_en,
  input  logic [NUM_COMMITS-1:0][AW-1:0]       cm_reg,
  input  logic [NUM_COMMITS-1:0][DATA_W-1:0]   cm_val,
  output logic [DATA_W-1:0]                    fwd_val
);

  always_comb begin
    fwd_val = arr_val;
    // Ascending scan so a later (higher) port overrides an earlier match.
    for (int i = 0; i < NUM_COMMITS; i++) begin
      if (cm_wr_en[i] && (cm_reg[i] == rd_addr)) fwd_val = cm_val[i];
    end
    if (RF_X0_ZERO && (rd_addr == '0)) fwd_val = '0;
  end

endmodule

// File: rtl/arch_regfile_mp.sv
// Multi-port architectural register file: commit writes, forwarded registered reads, bulk clear.
// ARCH_RF_X0_ZERO_EN (see arch_rf_pkg) makes register 0 read-only zero.
module arch_regfile_mp
  import arch_rf_pkg::*;
#(
  parameter int NUM_REGS       = RF_NUM_REGS,
  parameter int DATA_W         = RF_DATA_W,
  parameter int NUM_COMMITS    = RF_NUM_COMMITS,
  parameter int NUM_READ_PORTS = 2,
  parameter int CLR_PER_CYC    = RF_CLR_PER_CYC,
  localparam int AW            = $clog2(NUM_REGS)
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [NUM_READ_PORTS-1:0]                 rd_req,
  input  logic [NUM_READ_PORTS-1:0][AW-1:0]         rd_addr,
  output logic                                      rd_ready,
  output logic [NUM_READ_PORTS-1:0]                 rd_valid,
  output logic [NUM_READ_PORTS-1:0][DATA_W-1:0]     rd_data,
  input  logic [NUM_COMMITS-1:0]                    cm_wr_en,
  input  logic [NUM_COMMITS-1:0][AW-1:0]            cm_reg,
  input  logic [NUM_COMMITS-1:0][DATA_W-1:0]        cm_val,
  output logic                                      cm_stall,
  input  logic                                      clr_req,
  output logic                                      clr_busy,
  output logic                                      clr_done,
  output logic                                      err_wr_drop
);

  localparam int SWEEPS = NUM_REGS / CLR_PER_CYC;
  localparam int CNT_W  = cnt_width(SWEEPS);
  localparam logic [CNT_W-1:0] LAST_SWEEP = CNT_W'(SWEEPS - 1);

  arch_rf_state_e                         state_q, state_d;
  logic [CNT_W-1:0]                       cnt_q, cnt_d;
  logic [DATA_W-1:0]                      regs_q [NUM_REGS];
  logic [DATA_W-1:0]                      regs_d [NUM_REGS];
  logic [NUM_READ_PORTS-1:0]              rd_valid_q, rd_valid_d;
  logic [NUM_READ_PORTS-1:0][DATA_W-1:0]  rd_data_q, rd_data_d, fwd_data;
  logic                                   err_q, err_d;
  logic                                   idle;
  logic [AW-1:0]                          clr_idx;

  assign idle        = (state_q == RF_IDLE);
  assign rd_ready    = idle;
  assign cm_stall    = !idle;
  assign clr_busy    = !idle;
  assign clr_done    = !idle && (cnt_q == LAST_SWEEP);
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign err_wr_drop = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      RF_IDLE: begin
        if (clr_req) state_d = RF_CLEAR;
      end
      RF_CLEAR: begin
        if (|cm_wr_en) err_d = 1'b1;
        if (cnt_q == LAST_SWEEP) begin
          state_d = RF_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RF_IDLE;
    endcase
  end

  always_comb begin
    clr_idx = '0;
    for (int r = 0; r < NUM_REGS; r++) regs_d[r] = regs_q[r];
    if (idle) begin
      // Later ports overwrite earlier ones, giving highest-index priority.
      for (int i = 0; i < NUM_COMMITS; i++) begin
        if (cm_wr_en[i] && !(RF_X0_ZERO && (cm_reg[i] == '0))) regs_d[cm_reg[i]] = cm_val[i];
      end
    end else begin
      for (int k = 0; k < CLR_PER_CYC; k++) begin
        clr_idx         = AW'(int'(cnt_q) * CLR_PER_CYC + k);
        regs_d[clr_idx] = '0;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_READ_PORTS; gi++) begin : g_rd
    arch_rf_fwd_mux #(
      .DATA_W      (DATA_W),
      .NUM_COMMITS (NUM_COMMITS),
      .AW          (AW)
    ) u_fwd (
      .rd_addr  (rd_addr[gi]),
      .arr_val  (regs_q[rd_addr[gi]]),
      .cm_wr_en (cm_wr_en),
      .cm_reg   (cm_reg),
      .cm_val   (cm_val),
      .fwd_val  (fwd_data[gi])
    );

    assign rd_valid_d[gi] = rd_req[gi] && idle;
    assign rd_data_d[gi]  = rd_valid_d[gi] ? fwd_data[gi] : rd_data_q[gi];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RF_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= DATA_W'(r);
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= regs_d[r];
    end
  end

endmodule
